// File: rtl/cpu_usm_pkg.sv
// Shared encodings for the cpu_usm_v1 multicycle control unit: FSM states,
// opcodes, ALU control codes and the select meanings used at the datapath mux sites.
package cpu_usm_pkg;

    localparam int OP_W     = 7;
    localparam int ALUCTL_W = 3;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
    localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_decode(input logic [OP_W-1:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the FSM's alu_op class plus instruction funct bits to
// the datapath alu_control code.
module alu_dec
    import cpu_usm_pkg::*;
#(
    parameter int ALUCTL_W_P = ALUCTL_W
) (
    input  alu_op_t               i_alu_op,
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7b5,
    input  logic                  i_op5,
    output logic [ALUCTL_W_P-1:0] o_alu_control
);

    // Only R-type (op[5]=1) can subtract via funct7; addi ignores funct7b5.
    logic w_is_sub;
    assign w_is_sub = i_funct7b5 & i_op5;

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = w_is_sub ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I-subset control unit: state register plus combinational
// next-state and datapath control, with a mem_ready stall on fetch/load/store.
module mc_controller
    import cpu_usm_pkg::*;
#(
    parameter int OP_W_P     = OP_W,
    parameter int ALUCTL_W_P = ALUCTL_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [OP_W_P-1:0]     op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [ALUCTL_W_P-1:0] alu_control,
    output logic                  reg_write,
    output logic                  illegal_instr,
    output logic [3:0]            state_dbg
);

    state_t  r_state;
    state_t  w_next;
    alu_op_t w_alu_op;
    logic    w_pc_update;
    logic    w_branch;
    logic [ALUCTL_W_P-1:0] w_alu_control;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = S_FETCH;
        w_alu_op      = ALUOP_ADD;
        w_pc_update   = 1'b0;
        w_branch      = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_WDATA;
        imm_src       = IMM_I;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        state_dbg     = 4'd0;
        // Reset dominates: every output stays at its zero default.
        if (!reset) begin
            state_dbg = r_state;
            imm_src   = imm_decode(op);
            case (r_state)
                S_FETCH: begin
                    alu_src_b   = SRCB_FOUR;
                    result_src  = RES_ALURESULT;
                    ir_write    = mem_ready;
                    w_pc_update = mem_ready;
                    w_next      = mem_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    case (op)
                        OP_LW, OP_SW: w_next = S_MEMADR;
                        OP_R:         w_next = S_EXECR;
                        OP_I:         w_next = S_EXECI;
                        OP_BEQ:       w_next = S_BEQ;
                        OP_JAL:       w_next = S_JAL;
                        default: begin
                            illegal_instr = 1'b1;
                            w_next        = S_FETCH;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = SRCA_A;
                    alu_src_b = SRCB_IMM;
                    w_next    = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                end
                S_MEMREAD: begin
                    adr_src = 1'b1;
                    w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    // Strobe held until memory accepts, so one sw is one completed write.
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                    w_next    = mem_ready ? S_FETCH : S_MEMWRITE;
                end
                S_EXECR: begin
                    alu_src_a = SRCA_A;
                    alu_src_b = SRCB_WDATA;
                    w_alu_op  = ALUOP_FUNCT;
                    w_next    = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a = SRCA_A;
                    alu_src_b = SRCB_IMM;
                    w_alu_op  = ALUOP_FUNCT;
                    w_next    = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = SRCA_A;
                    alu_src_b = SRCB_WDATA;
                    w_alu_op  = ALUOP_SUB;
                    w_branch  = 1'b1;
                end
                S_JAL: begin
                    alu_src_a   = SRCA_OLDPC;
                    alu_src_b   = SRCB_FOUR;
                    w_pc_update = 1'b1;
                    w_next      = S_ALUWB;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

    alu_dec #(.ALUCTL_W_P(ALUCTL_W_P)) u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (w_alu_control)
    );

    assign alu_control = w_alu_control;
    assign pc_write    = w_pc_update | (w_branch & zero);

endmodule
